// File: rtl/fft_r2_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT: walks stages and butterflies,
// issues read/twiddle addresses and pipeline-delayed write-back addresses.
module fft_r2_sequencer #(
  parameter int unsigned N        = 32,
  parameter int unsigned LOG2N    = 5,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic [2:0]       stage
);

  localparam int unsigned AW  = LOG2N;
  localparam int unsigned BW  = LOG2N - 1;
  localparam int unsigned SW  = 3;
  localparam int unsigned PW  = 1 + 2 * AW;
  localparam int unsigned DLW = PIPE_LAT * PW;
  localparam int unsigned DW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [BW-1:0] BF_LAST  = BW'(N / 2 - 1);
  localparam logic [SW-1:0] STG_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] DRN_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bf_q, bf_d;
  logic [SW-1:0]   stg_q, stg_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0]   rd_addr_b_q, rd_addr_b_d;
  logic [BW-1:0]   tw_addr_q, tw_addr_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [DLW-1:0]  pipe_q, pipe_d;

  logic [AW-1:0]   bf_ext, half, pos, base_addr;
  logic [PW-1:0]   pipe_out;

  // Butterfly pair decode: base = group * 2 * half, pos = offset within group
  always_comb begin
    bf_ext    = AW'(bf_q);
    half      = AW'(1) << stg_q;
    pos       = bf_ext & (half - AW'(1));
    base_addr = (bf_ext & ~(half - AW'(1))) << 1;
  end

  always_comb begin
    state_d     = state_q;
    bf_d        = bf_q;
    stg_d       = stg_q;
    drn_d       = drn_q;
    rd_en_d     = 1'b0;
    rd_addr_a_d = '0;
    rd_addr_b_d = '0;
    tw_addr_d   = '0;
    busy_d      = (state_q == RUN) || (state_q == DRAIN);
    done_d      = (state_q == DONE);
    stage_d     = stg_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          bf_d    = '0;
          stg_d   = '0;
        end
      end
      RUN: begin
        rd_en_d     = 1'b1;
        rd_addr_a_d = base_addr | pos;
        rd_addr_b_d = (base_addr | pos) + half;
        tw_addr_d   = BW'(pos << (SW'(LOG2N - 1) - stg_q));
        if (bf_q == BF_LAST) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          bf_d = bf_q + BW'(1);
        end
      end
      DRAIN: begin
        // Gap lets the stage's last write retire before the next stage reads
        if (drn_q == DRN_LAST) begin
          if (stg_q == STG_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stg_d   = stg_q + SW'(1);
            bf_d    = '0;
          end
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        stg_d   = '0;
        bf_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-back delay line tracking read issue through RAM + butterfly latency
  always_comb begin
    pipe_d = (pipe_q << PW) | DLW'({rd_en_q, rd_addr_a_q, rd_addr_b_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bf_q        <= '0;
      stg_q       <= '0;
      drn_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      stage_q     <= '0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      bf_q        <= bf_d;
      stg_q       <= stg_d;
      drn_q       <= drn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      stage_q     <= stage_d;
      pipe_q      <= pipe_d;
    end
  end

  assign pipe_out  = pipe_q[DLW-1 -: PW];
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr   = tw_addr_q;
  assign stage     = stage_q;
  assign wr_en     = pipe_out[PW-1];
  assign wr_addr_a = pipe_out[PW-2 -: AW];
  assign wr_addr_b = pipe_out[AW-1:0];

endmodule

// File: doc/fft_r2_sequencer.md
Name: fft_r2_sequencer

Overview:
Control sequencer for the 32-point radix-2 DIT FFT butterfly datapath. It walks all LOG2N stages of N/2 butterflies each and issues in-place data-memory read addresses for the butterfly pair. It also issues the twiddle ROM index and the write-back addresses and write enable, delayed to match the read + butterfly pipeline. Input data sits in memory in bit-reversed order; output comes out in natural order, in place.

Parameters:
N, 32, FFT size (power of two)
LOG2N, 5, log2(N); address width
PIPE_LAT, 2, cycles from read-address issue to butterfly result valid (1 registered RAM read + 1 registered butterfly)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
start  in  1  request one full FFT pass; sampled only in IDLE
busy  out  1  high while a pass is in progress
done  out  1  one-cycle pulse when the pass is complete
rd_en  out  1  read/issue valid for the butterfly pair
rd_addr_a  out  LOG2N  upper-leg (In1) read address
rd_addr_b  out  LOG2N  lower-leg (In2) read address
tw_addr  out  LOG2N-1  twiddle ROM index k, meaning W_N^k
wr_en  out  1  write-back valid (both legs)
wr_addr_a  out  LOG2N  write address for Out1 (sum)
wr_addr_b  out  LOG2N  write address for Out2 (diff)
stage  out  3  current stage index, 0..LOG2N-1

Behaviour:
- Single clock domain, synchronous active-high reset.
- All outputs come from registers or from register-only decode. There is no combinational path from start to any output.
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, all address outputs 0, stage=0, FSM=IDLE, delay line cleared.
- FSM states and transitions:
  - IDLE -> RUN when start=1.
  - RUN issues one butterfly per cycle, bf = 0..N/2-1. After bf = N/2-1 it goes to DRAIN.
  - DRAIN lasts exactly PIPE_LAT cycles with rd_en=0. It then goes to RUN with stage+1 and bf=0, or to DONE if stage = LOG2N-1.
  - DONE lasts one cycle with done=1, then goes to IDLE.
- Address generation in RUN, with s = stage and half = 1<<s:
  - pos = bf & (half-1); grp = bf >> s.
  - rd_addr_a = grp*2*half + pos; rd_addr_b = rd_addr_a + half.
  - tw_addr = pos << (LOG2N-1-s).
- Write-back path: {rd_en, rd_addr_a, rd_addr_b} passes through a PIPE_LAT-deep shift register and emerges as {wr_en, wr_addr_a, wr_addr_b}.
- The DRAIN gap guarantees the last write of stage s commits before the first read of stage s+1 (no RAW hazard).
- busy=1 from the first RUN cycle through the last DRAIN cycle. busy=0 in IDLE and DONE.
- Timing with start sampled at edge 0:
  - first rd_en in cycle 1; first wr_en in cycle 1+PIPE_LAT.
  - each stage takes N/2+PIPE_LAT cycles.
  - last wr_en in cycle LOG2N*(N/2+PIPE_LAT) = 90; done in cycle 91.
- Boundary conditions:
  - start while busy or in DONE: ignored, not queued.
  - start held high continuously: a new pass begins on the first IDLE cycle, i.e. the cycle after done.
  - rst mid-pass: return to IDLE next cycle and flush the delay line; wr_en=0 immediately after reset, so in-flight writes are dropped.
  - rst and start together: rst wins.
- Counters wrap only under FSM control. bf and stage never free-run outside RUN/DRAIN.

Test Plan:
- Reset then idle: after rst, hold start=0 for 20 cycles -> busy=0, done=0, rd_en=0, wr_en=0, all addresses 0.
- Stage 0 sequence: pulse start -> cycles 1..16 show rd_addr_a/b = (0,1),(2,3)..(30,31), tw_addr=0 throughout; wr_en cycles 3..18 with the same pairs.
- Later stages:
  - stage 2: bf=5 -> rd (9,13), tw_addr=4.
  - stage 4: bf=0..15 -> rd (k,k+16), tw_addr=k.
  - drain: rd_en=0 for exactly 2 cycles between stages.
- Full pass against golden model: start -> 80 rd_en cycles, 80 wr_en cycles, last wr_en in cycle 90, done=1 only in cycle 91, busy falls in cycle 91. With a behavioural RAM + butterfly model and a bit-reversed impulse at x[0], all 32 bins equal the input value.
- Start while busy / held high: re-pulse start at cycle 40 -> no effect, done still at 91. Hold start=1 -> second pass issues its first rd_en at cycle 93.
- Reset mid-pass: assert rst at cycle 50 for 1 cycle -> next cycle busy=0, wr_en=0, stage=0. A fresh start then runs a complete 91-cycle pass.
